// File: rtl/hs_ram_arbiter.sv
// Arbitrates the work-RAM port between the CPU path and the hiscore engine, pausing the core around each hiscore access.
// Optional vblank watchdog is enabled by defining HS_ARB_TIMEOUT_EN.
module hs_ram_arbiter #(
    parameter int AW          = 16,
    parameter int SETTLE_CYC  = 16,
    parameter int DRAIN_CYC   = 4,
    parameter int TIMEOUT_CYC = 800000
) (
    input  logic          clk_sys,
    input  logic          RESET,
    input  logic          vblank,
    input  logic          hs_req,
    input  logic [AW-1:0] hs_addr,
    input  logic [7:0]    hs_wdata,
    input  logic          hs_we,
    output logic [7:0]    hs_rdata,
    output logic          hs_grant,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    input  logic          cpu_we,
    output logic [7:0]    cpu_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    output logic          ram_we,
    input  logic [7:0]    ram_rdata,
    output logic          pause_req,
    output logic          timeout_flag
);

    localparam int CNT_MAX = (SETTLE_CYC > DRAIN_CYC) ? SETTLE_CYC : DRAIN_CYC;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    if (SETTLE_CYC < 1 || DRAIN_CYC < 1 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("hs_ram_arbiter: SETTLE_CYC and DRAIN_CYC must be >= 1, TIMEOUT_CYC >= 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VBL,
        SETTLE,
        GRANT,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pause_q, pause_d;
    logic          grant_q, grant_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          vbl1_q, vbl2_q;
    logic          vbl_rise;
    logic          hs_sel;

`ifdef HS_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC) + 1;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          tflag_q, tflag_d;
    assign timeout_flag = tflag_q;
`else
    assign timeout_flag = 1'b0;
`endif

    // Edge is taken from two registered copies, so it reaches the FSM one cycle late.
    assign vbl_rise = vbl1_q & ~vbl2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pause_d = pause_q;
        grant_d = grant_q;
        rdata_d = rdata_q;
`ifdef HS_ARB_TIMEOUT_EN
        wdog_d  = '0;
        tflag_d = tflag_q;
`endif
        if (grant_q) begin
            rdata_d = ram_rdata;
        end
        case (state_q)
            IDLE: begin
                if (hs_req) begin
                    state_d = WAIT_VBL;
                    pause_d = 1'b1;
                end
            end
            WAIT_VBL: begin
                if (!hs_req) begin
                    state_d = IDLE;
                    pause_d = 1'b0;
                end else if (vbl_rise) begin
                    state_d = SETTLE;
                    cnt_d   = CW'(SETTLE_CYC - 1);
                end
`ifdef HS_ARB_TIMEOUT_EN
                else if (wdog_q == WW'(TIMEOUT_CYC - 1)) begin
                    state_d = SETTLE;
                    cnt_d   = CW'(SETTLE_CYC - 1);
                    tflag_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
`endif
            end
            SETTLE: begin
                if (!hs_req) begin
                    state_d = IDLE;
                    pause_d = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = GRANT;
                    grant_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GRANT: begin
                if (!hs_req) begin
                    state_d = DRAIN;
                    grant_d = 1'b0;
                    cnt_d   = CW'(DRAIN_CYC - 1);
                end
            end
            DRAIN: begin
                // A new request while still paused goes straight back to the grant.
                if (hs_req) begin
                    state_d = GRANT;
                    grant_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                    pause_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                pause_d = 1'b0;
                grant_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        vbl1_q <= vblank;
        vbl2_q <= vbl1_q;
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pause_q <= 1'b0;
            grant_q <= 1'b0;
            rdata_q <= 8'h00;
`ifdef HS_ARB_TIMEOUT_EN
            wdog_q  <= '0;
            tflag_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pause_q <= pause_d;
            grant_q <= grant_d;
            rdata_q <= rdata_d;
`ifdef HS_ARB_TIMEOUT_EN
            wdog_q  <= wdog_d;
            tflag_q <= tflag_d;
`endif
        end
    end

    // Reset blocks the hiscore path immediately so no hiscore write escapes during reset.
    assign hs_sel    = grant_q & ~RESET;
    assign ram_addr  = hs_sel ? hs_addr  : cpu_addr;
    assign ram_wdata = hs_sel ? hs_wdata : cpu_wdata;
    assign ram_we    = hs_sel ? hs_we    : cpu_we;
    assign cpu_rdata = ram_rdata;
    assign hs_rdata  = rdata_q;
    assign hs_grant  = grant_q;
    assign pause_req = pause_q;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Self-checking bench for hs_ram_arbiter: randomized hiscore sessions against a timing/RAM reference model.
module tb_hs_ram_arbiter;

    localparam int AW = 16;
    localparam int S  = 16;
    localparam int D  = 4;
    localparam int T  = 100;

    logic          clk_sys = 1'b0;
    logic          RESET = 1'b1;
    logic          vblank = 1'b0;
    logic          hs_req = 1'b0;
    logic [AW-1:0] hs_addr = '0;
    logic [7:0]    hs_wdata = '0;
    logic          hs_we = 1'b0;
    logic [7:0]    hs_rdata;
    logic          hs_grant;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_wdata = '0;
    logic          cpu_we = 1'b0;
    logic [7:0]    cpu_rdata;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic          ram_we;
    logic [7:0]    ram_rdata = '0;
    logic          pause_req;
    logic          timeout_flag;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:65535];
    logic [7:0] exp_mem [int];

    hs_ram_arbiter #(
        .AW(AW), .SETTLE_CYC(S), .DRAIN_CYC(D), .TIMEOUT_CYC(T)
    ) dut (
        .clk_sys(clk_sys), .RESET(RESET), .vblank(vblank),
        .hs_req(hs_req), .hs_addr(hs_addr), .hs_wdata(hs_wdata), .hs_we(hs_we),
        .hs_rdata(hs_rdata), .hs_grant(hs_grant),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .pause_req(pause_req), .timeout_flag(timeout_flag)
    );

    always #5 clk_sys = ~clk_sys;

    // Synchronous-read work RAM with one cycle of read latency.
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Request, wait for a vblank edge, and expect the grant exactly S+1 cycles after it.
    task automatic go_to_grant();
        logic exp_g;
        vblank = 1'b0;
        hs_req = 1'b1;
        tick();
        checks++;
        if (pause_req !== 1'b1 || hs_grant !== 1'b0)
            $display("[TB] FAIL req_pause: pause=%0b grant=%0b expected pause=1 grant=0", pause_req, hs_grant);
        repeat ($urandom_range(2, 6)) tick();
        vblank = 1'b1;
        for (int i = 0; i <= S + 1; i++) begin
            tick();
            exp_g = (i == S + 1);
            checks++;
            if (hs_grant !== exp_g) begin
                errors++;
                $display("[TB] FAIL grant_timing: cycle %0d after vblank grant=%0b expected %0b", i, hs_grant, exp_g);
            end
        end
        vblank = 1'b0;
    endtask

    task automatic quiet_release();
        hs_req = 1'b0;
        hs_we  = 1'b0;
        repeat (D + 2) tick();
    endtask

    task automatic test_reset();
        RESET  = 1'b1;
        hs_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_addr  = AW'($urandom);
            cpu_wdata = 8'($urandom);
            cpu_we    = i[0];
            #1;
            checks++;
            if (ram_we !== cpu_we) begin
                errors++;
                $display("[TB] FAIL reset_ram_we: got %0b expected %0b", ram_we, cpu_we);
            end
            if (cpu_we) exp_mem[int'(cpu_addr)] = cpu_wdata;
            tick();
        end
        checks++;
        if (pause_req !== 1'b0 || hs_grant !== 1'b0 || hs_rdata !== 8'h00 || timeout_flag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: pause=%0b grant=%0b rdata=%0h tflag=%0b expected 0 0 00 0",
                     pause_req, hs_grant, hs_rdata, timeout_flag);
        end
        cpu_we = 1'b0;
        hs_req = 1'b0;
        RESET  = 1'b0;
        tick();
    endtask

    task automatic test_full_access();
        logic [AW-1:0] addrs [$];
        logic [AW-1:0] a;
        logic [7:0]    d;
        go_to_grant();
        addrs.push_back(16'h1234);
        for (int i = 0; i < 8; i++) addrs.push_back(AW'($urandom));
        foreach (addrs[i]) begin
            a = addrs[i];
            d = (i == 0) ? 8'hA5 : 8'($urandom);
            hs_addr  = a;
            hs_wdata = d;
            hs_we    = 1'b1;
            #1;
            checks++;
            if (ram_we !== 1'b1 || ram_addr !== a || ram_wdata !== d) begin
                errors++;
                $display("[TB] FAIL hs_write_mux: we=%0b addr=%0h data=%0h expected 1 %0h %0h",
                         ram_we, ram_addr, ram_wdata, a, d);
            end
            tick();
            exp_mem[int'(a)] = d;
        end
        hs_we = 1'b0;
        // Pipelined reads: data for the address driven on cycle j shows up after cycle j+1.
        for (int j = 0; j <= addrs.size(); j++) begin
            if (j < addrs.size()) hs_addr = addrs[j];
            tick();
            if (j >= 1) begin
                checks++;
                if (hs_rdata !== exp_mem[int'(addrs[j-1])]) begin
                    errors++;
                    $display("[TB] FAIL hs_readback: addr %0h got %0h expected %0h",
                             addrs[j-1], hs_rdata, exp_mem[int'(addrs[j-1])]);
                end
            end
        end
        checks++;
        if (cpu_rdata !== ram_rdata) begin
            errors++;
            $display("[TB] FAIL cpu_rdata_pass: got %0h expected %0h", cpu_rdata, ram_rdata);
        end
        quiet_release();
    endtask

    task automatic test_release();
        logic exp_p;
        go_to_grant();
        hs_addr  = AW'($urandom);
        hs_req   = 1'b0;
        cpu_addr = AW'($urandom);
        tick();
        checks++;
        if (hs_grant !== 1'b0 || ram_addr !== cpu_addr || pause_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_grant: grant=%0b ram_addr=%0h pause=%0b expected 0 %0h 1",
                     hs_grant, ram_addr, cpu_addr, pause_req);
        end
        for (int k = 1; k <= D; k++) begin
            tick();
            exp_p = (k < D);
            checks++;
            if (pause_req !== exp_p) begin
                errors++;
                $display("[TB] FAIL release_pause: cycle %0d pause=%0b expected %0b", k, pause_req, exp_p);
            end
        end
        tick();
    endtask

    task automatic test_reentry();
        int m;
        logic bad;
        go_to_grant();
        hs_req = 1'b0;
        tick();
        m   = $urandom_range(0, D - 1);
        bad = 1'b0;
        repeat (m) begin
            tick();
            if (pause_req !== 1'b1) bad = 1'b1;
        end
        hs_req = 1'b1;
        tick();
        checks++;
        if (bad || hs_grant !== 1'b1 || pause_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drain_reentry: grant=%0b pause=%0b dropped=%0b expected 1 1 0", hs_grant, pause_req, bad);
        end
        quiet_release();
    endtask

    // Drop the request while counting down; count c remains before the drop.
    task automatic test_abort(input int c);
        logic seen;
        vblank = 1'b0;
        hs_req = 1'b1;
        repeat (3) tick();
        vblank = 1'b1;
        repeat (S - c + 1) tick();
        hs_req = 1'b0;
        tick();
        checks++;
        if (pause_req !== 1'b0 || hs_grant !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_pause: count %0d pause=%0b grant=%0b expected 0 0", c, pause_req, hs_grant);
        end
        seen = 1'b0;
        repeat (S + 4) begin
            tick();
            if (hs_grant !== 1'b0 || pause_req !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_idle: count %0d activity=%0b expected 0", c, seen);
        end
        vblank = 1'b0;
        tick();
    endtask

    task automatic test_cpu_isolation();
        logic [AW-1:0] iso;
        logic [7:0]    orig;
        logic          bad;
        iso       = 16'hBEEF;
        orig      = 8'($urandom);
        cpu_addr  = iso;
        cpu_wdata = orig;
        cpu_we    = 1'b1;
        tick();
        exp_mem[int'(iso)] = orig;
        cpu_we = 1'b0;
        go_to_grant();
        bad = 1'b0;
        cpu_we = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cpu_wdata = ~orig;
            hs_we     = i[0];
            hs_addr   = 16'h4000 + AW'(i);
            hs_wdata  = 8'($urandom);
            #1;
            if (ram_we !== hs_we) bad = 1'b1;
            tick();
            if (hs_we) exp_mem[int'(hs_addr)] = hs_wdata;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL iso_ram_we: ram_we followed cpu_we during grant, expected hs_we only");
        end
        cpu_we = 1'b0;
        quiet_release();
        checks++;
        if (mem[iso] !== exp_mem[int'(iso)]) begin
            errors++;
            $display("[TB] FAIL iso_contents: mem[%0h]=%0h expected %0h", iso, mem[iso], exp_mem[int'(iso)]);
        end
    endtask

    task automatic test_vblank_high_on_entry();
        logic seen;
        vblank = 1'b1;
        repeat (4) tick();
        hs_req = 1'b1;
        seen = 1'b0;
        repeat (S + 10) begin
            tick();
            if (hs_grant !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL midblank_grant: grant issued inside an already-running blank");
        end
        go_to_grant();
        quiet_release();
    endtask

    task automatic test_reset_mid();
        go_to_grant();
        hs_addr  = AW'($urandom);
        hs_wdata = 8'($urandom);
        hs_we    = 1'b1;
        cpu_we   = 1'b0;
        RESET    = 1'b1;
        #1;
        checks++;
        if (ram_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_we: ram_we=%0b expected 0", ram_we);
        end
        tick();
        checks++;
        if (hs_grant !== 1'b0 || pause_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_state: grant=%0b pause=%0b expected 0 0", hs_grant, pause_req);
        end
        RESET  = 1'b0;
        hs_req = 1'b0;
        hs_we  = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        int first;
        vblank = 1'b0;
        hs_req = 1'b1;
        first  = -1;
        for (int n = 1; n <= 10000 && first < 0; n++) begin
            tick();
            if (hs_grant === 1'b1) first = n;
        end
`ifdef HS_ARB_TIMEOUT_EN
        checks++;
        if (first != T + S + 1 || timeout_flag !== 1'b1) begin
            errors++;
            $display("[TB] FAIL watchdog_grant: grant at %0d tflag=%0b expected %0d 1", first, timeout_flag, T + S + 1);
        end
`else
        checks++;
        if (first != -1 || timeout_flag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL watchdog_off: grant at %0d tflag=%0b expected none 0", first, timeout_flag);
        end
`endif
        quiet_release();
    endtask

    initial begin
        test_reset();
        test_full_access();
        test_release();
        test_reentry();
        test_abort(5);
        test_abort($urandom_range(0, S - 1));
        test_cpu_isolation();
        test_vblank_high_on_entry();
        test_reset_mid();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
